param_sync_fifo: RTL

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_mem.sv | 25 ++
 rtl/param_sync_fifo.sv | 116 +++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing helpers and default thresholds for the synchronous FIFO.
package fifo_pkg;

  localparam int DEFAULT_AEMPTY_THRESH = 2;
  localparam int DEFAULT_AFULL_MARGIN  = 2;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Register-file storage: one synchronous write port, one asynchronous read port.
module fifo_mem #(
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with binary wrap-bit pointers, threshold flags, sticky
// error flags and a choice of registered or first-word-fall-through read data.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int FIFO_DEPTH    = 8,
  parameter int FIFO_WIDTH    = 4,
  parameter int AFULL_THRESH  = FIFO_DEPTH - DEFAULT_AFULL_MARGIN,
  parameter int AEMPTY_THRESH = DEFAULT_AEMPTY_THRESH,
  parameter int FWFT          = 0,
  localparam int ADDR_WIDTH   = addr_width(FIFO_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wen,
  input  logic [FIFO_WIDTH-1:0] i_wdata,
  input  logic                  i_ren,
  output logic [FIFO_WIDTH-1:0] o_rdata,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_afull,
  output logic                  o_aempty,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  if (!is_pow2(FIFO_DEPTH) || FIFO_DEPTH < 4) begin : g_bad_depth
    $error("param_sync_fifo: FIFO_DEPTH must be a power of two and at least 4");
  end
  if (AEMPTY_THRESH >= AFULL_THRESH) begin : g_bad_thresh
    $error("param_sync_fifo: AEMPTY_THRESH must be below AFULL_THRESH");
  end
  if (AFULL_THRESH > FIFO_DEPTH || AEMPTY_THRESH < 0) begin : g_bad_range
    $error("param_sync_fifo: thresholds must lie within 0..FIFO_DEPTH");
  end

  localparam logic [ADDR_WIDTH:0] AFULL_CNT  = AFULL_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AEMPTY_CNT = AEMPTY_THRESH[ADDR_WIDTH:0];

  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  overflow_q;
  logic                  underflow_q;
  logic [FIFO_WIDTH-1:0] head_data;

  // Status derived straight from the pointers so count and flags always agree.
  assign o_empty  = (wr_ptr == rd_ptr);
  assign o_full   = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                    (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign o_count  = wr_ptr - rd_ptr;
  assign o_afull  = (o_count >= AFULL_CNT);
  assign o_aempty = (o_count <= AEMPTY_CNT);

  assign wr_acc = i_wen && !o_full;
  assign rd_acc = i_ren && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (i_wen && o_full) begin
        overflow_q <= 1'b1;
      end
      if (i_ren && o_empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign o_overflow  = overflow_q;
  assign o_underflow = underflow_q;

  fifo_mem #(
    .DEPTH  (FIFO_DEPTH),
    .WIDTH  (FIFO_WIDTH),
    .ADDR_W (ADDR_WIDTH)
  ) u_mem (
    .clk   (i_clk),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (i_wdata),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (head_data)
  );

  if (FWFT != 0) begin : g_fwft
    // Head entry is presented directly; forced to zero while empty.
    assign o_rdata = o_empty ? '0 : head_data;
  end else begin : g_reg_read
    logic [FIFO_WIDTH-1:0] rdata_p1;

    // Read stage: the head entry is captured on the edge that accepts the read.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        rdata_p1 <= '0;
      end else if (rd_acc) begin
        rdata_p1 <= head_data;
      end
    end

    assign o_rdata = rdata_p1;
  end

endmodule
